// File: rtl/seg_display_arbiter_pkg.sv
// seg_display_arbiter_pkg
//   Shared segment constants, digit-code encoding and scan FSM state type
//   for the seven-segment display arbiter. Segment bytes are {a,b,c,d,e,f,g,dp},
//   active-low.
package seg_display_arbiter_pkg;

    localparam logic [7:0] SEG_0     = 8'h03;
    localparam logic [7:0] SEG_1     = 8'h9F;
    localparam logic [7:0] SEG_2     = 8'h25;
    localparam logic [7:0] SEG_3     = 8'h0D;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h49;
    localparam logic [7:0] SEG_6     = 8'h41;
    localparam logic [7:0] SEG_7     = 8'h1F;
    localparam logic [7:0] SEG_8     = 8'h01;
    localparam logic [7:0] SEG_9     = 8'h09;
    localparam logic [7:0] SEG_DASH  = 8'hFD;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Digit code: bit 4 forces blank, bits 3:0 carry the value.
    localparam logic [4:0] BLANK_CODE = 5'h10;

    localparam int unsigned NUM_DIGITS = 8;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_ON    = 1'b1
    } scan_state_e;

endpackage

// File: rtl/seg_display_arbiter_if.sv
// seg_display_arbiter_if
//   One requester's digit-write channel.
//   req  : write request, held until granted
//   addr : digit index (0 = rightmost, led_en bit 0)
//   data : digit code {blank, value[3:0]}
//   gnt  : combinational grant; the write commits on the clock edge where gnt=1
interface seg_display_arbiter_if;
    logic       req;
    logic [2:0] addr;
    logic [4:0] data;
    logic       gnt;

    modport master (output req, output addr, output data, input gnt);
    modport slave  (input req, input addr, input data, output gnt);
endinterface

// File: rtl/seg_display_arbiter_rr_arb2.sv
// seg_display_arbiter_rr_arb2
//   Two-way round-robin arbiter. A lone requester is granted immediately;
//   on contention the requester that did not win last time is granted.
//   Ports:
//     clk, rst        : clock, async active-high reset
//     req0_i, req1_i  : requests
//     gnt0_o, gnt1_o  : combinational grants, mutually exclusive, low in reset
module seg_display_arbiter_rr_arb2 (
    input  logic clk,
    input  logic rst,
    input  logic req0_i,
    input  logic req1_i,
    output logic gnt0_o,
    output logic gnt1_o
);

    // Index of the requester granted most recently; resets to 1 so that
    // requester 0 wins the first contention.
    logic rr_last_q;
    logic rr_last_d;

    always_comb begin
        gnt0_o = 1'b0;
        gnt1_o = 1'b0;
        if (!rst) begin
            if (req0_i && (!req1_i || rr_last_q)) begin
                gnt0_o = 1'b1;
            end else if (req1_i) begin
                gnt1_o = 1'b1;
            end
        end
    end

    always_comb begin
        rr_last_d = rr_last_q;
        if (gnt0_o) begin
            rr_last_d = 1'b0;
        end else if (gnt1_o) begin
            rr_last_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_last_q <= 1'b1;
        end else begin
            rr_last_q <= rr_last_d;
        end
    end

endmodule

// File: rtl/seg_display_arbiter.sv
// seg_display_arbiter
//   Owns the 8-digit active-low seven-segment display. Two requesters write
//   digit codes into an 8-entry buffer through a round-robin arbiter (one write
//   per clock). A scan sequencer walks the digits, one per slot of SCAN_DIV+1
//   clocks, keeping all digits dark for the first BLANK_CYC clocks of a slot.
//   Ports:
//     clk, rst  : clock, async active-high reset
//     wr0, wr1  : requester write channels (slave side)
//     led_en    : digit enables, active-low, one-hot-low or all ones (registered)
//     led_cx    : segments {a..g,dp}, active-low (registered)
module seg_display_arbiter
    import seg_display_arbiter_pkg::*;
#(
    parameter int unsigned SCAN_DIV  = 199999,
    parameter int unsigned BLANK_CYC = 1000
) (
    input  logic                 clk,
    input  logic                 rst,
    seg_display_arbiter_if.slave wr0,
    seg_display_arbiter_if.slave wr1,
    output logic [7:0]           led_en,
    output logic [7:0]           led_cx
);

    localparam logic [31:0] SLOT_LAST  = 32'(SCAN_DIV);
    localparam logic [31:0] BLANK_LAST = 32'(BLANK_CYC - 1);

    function automatic logic [7:0] seg_decode(input logic [4:0] code);
        logic [7:0] seg;
        if (code[4]) begin
            seg = SEG_BLANK;
        end else begin
            case (code[3:0])
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_DASH;
            endcase
        end
        return seg;
    endfunction

    // ------------------------------------------------------------------
    // Arbitration and digit buffer
    // ------------------------------------------------------------------
    logic gnt0;
    logic gnt1;

    seg_display_arbiter_rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .req0_i (wr0.req),
        .req1_i (wr1.req),
        .gnt0_o (gnt0),
        .gnt1_o (gnt1)
    );

    assign wr0.gnt = gnt0;
    assign wr1.gnt = gnt1;

    logic [4:0] dig_q [NUM_DIGITS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NUM_DIGITS); i++) begin
                dig_q[i] <= BLANK_CODE;
            end
        end else if (gnt0) begin
            dig_q[wr0.addr] <= wr0.data;
        end else if (gnt1) begin
            dig_q[wr1.addr] <= wr1.data;
        end
    end

    // ------------------------------------------------------------------
    // Slot counter: 0..SCAN_DIV, wrapping
    // ------------------------------------------------------------------
    logic [31:0] cnt_q;
    logic [31:0] cnt_d;
    logic        slot_end;

    assign slot_end = (cnt_q == SLOT_LAST);
    assign cnt_d    = slot_end ? 32'd0 : cnt_q + 32'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 32'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Scan FSM. The segment pattern is latched once on ON entry, so a write
    // to the digit currently lit only shows on its next slot.
    // ------------------------------------------------------------------
    scan_state_e state_q;
    logic [2:0]  idx_q;
    logic [7:0]  led_en_q;
    logic [7:0]  led_cx_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_BLANK;
            idx_q    <= 3'd0;
            led_en_q <= 8'hFF;
            led_cx_q <= 8'hFF;
        end else begin
            case (state_q)
                ST_BLANK: begin
                    if (cnt_q == BLANK_LAST) begin
                        state_q  <= ST_ON;
                        led_en_q <= ~(8'b1 << idx_q);
                        led_cx_q <= seg_decode(dig_q[idx_q]);
                    end
                end
                ST_ON: begin
                    if (slot_end) begin
                        state_q  <= ST_BLANK;
                        idx_q    <= idx_q + 3'd1;
                        led_en_q <= 8'hFF;
                        led_cx_q <= 8'hFF;
                    end
                end
                default: state_q <= ST_BLANK;
            endcase
        end
    end

    assign led_en = led_en_q;
    assign led_cx = led_cx_q;

endmodule

// File: tb/tb_seg_display_arbiter.sv
module tb_seg_display_arbiter;

    localparam int SD = 7;
    localparam int BC = 2;
    localparam int P  = SD + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cmp_on = 1'b0;
    logic [7:0] led_en;
    logic [7:0] led_cx;

    seg_display_arbiter_if wr0 ();
    seg_display_arbiter_if wr1 ();

    seg_display_arbiter #(.SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
        .clk    (clk),
        .rst    (rst),
        .wr0    (wr0),
        .wr1    (wr1),
        .led_en (led_en),
        .led_cx (led_cx)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0] seg_tbl [16] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
                                 8'h01, 8'h09, 8'hFD, 8'hFD, 8'hFD, 8'hFD, 8'hFD, 8'hFD};

    function automatic logic [7:0] dec(input logic [4:0] c);
        return c[4] ? 8'hFF : seg_tbl[c[3:0]];
    endfunction

    int         t;          // clocks since reset release
    logic [4:0] mbuf [8];
    logic [7:0] lit_cx;     // pattern shown during current lit period
    int         last_win;   // requester granted most recently

    // Who wins this cycle: 0, 1, or -1 for nobody.
    function automatic int winner(input logic r, input logic q0, input logic q1, input int lw);
        if (r) return -1;
        if (q0 && q1) return (lw == 0) ? 1 : 0;
        if (q0) return 0;
        if (q1) return 1;
        return -1;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            t        <= 0;
            last_win <= 1;
            lit_cx   <= 8'hFF;
            for (int i = 0; i < 8; i++) mbuf[i] <= 5'h10;
        end else begin
            // Lit period begins with the buffer contents as they stand before this edge's write.
            if (t % P == BC - 1) lit_cx <= dec(mbuf[(t / P) % 8]);
            case (winner(rst, wr0.req, wr1.req, last_win))
                0: begin mbuf[wr0.addr] <= wr0.data; last_win <= 0; end
                1: begin mbuf[wr1.addr] <= wr1.data; last_win <= 1; end
                default: ;
            endcase
            t <= t + 1;
        end
    end

    logic [7:0] e_en, e_cx;
    int         w;
    always @(negedge clk) begin
        if (cmp_on) begin
            if (rst || (t % P) < BC) begin
                e_en = 8'hFF;
                e_cx = 8'hFF;
            end else begin
                e_en = ~(8'b1 << ((t / P) % 8));
                e_cx = lit_cx;
            end
            w = winner(rst, wr0.req, wr1.req, last_win);
            check("m_led_en", led_en, e_en);
            check("m_led_cx", led_cx, e_cx);
            check("m_gnt0", {7'b0, wr0.gnt}, {7'b0, w == 0});
            check("m_gnt1", {7'b0, wr1.gnt}, {7'b0, w == 1});
            check("gnt_excl", {7'b0, wr0.gnt & wr1.gnt}, 8'h00);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_req(input int port, input logic r, input logic [2:0] a, input logic [4:0] d);
        if (port == 0) begin wr0.req = r; wr0.addr = a; wr0.data = d; end
        else           begin wr1.req = r; wr1.addr = a; wr1.data = d; end
    endtask

    task automatic wr(input int port, input logic [2:0] a, input logic [4:0] d);
        int   n;
        logic g;
        @(posedge clk); #1;
        set_req(port, 1'b1, a, d);
        n = 0;
        g = 1'b0;
        while (!g && n < 20) begin
            @(negedge clk);
            g = (port == 0) ? wr0.gnt : wr1.gnt;
            if (!g) n++;
        end
        check("wr_grant_latency", 8'(n), 8'd0);
        @(posedge clk); #1;
        set_req(port, 1'b0, a, d);
    endtask

    task automatic wait_en(input logic [7:0] tgt, input string nm);
        int n;
        n = 0;
        @(negedge clk);
        while (led_en == tgt && n < 300) begin @(negedge clk); n++; end
        while (led_en != tgt && n < 300) begin @(negedge clk); n++; end
        if (n >= 300) check({nm, "_timeout"}, 8'd1, 8'd0);
    endtask

    initial begin
        set_req(0, 1'b0, 3'd0, 5'h00);
        set_req(1, 1'b0, 3'd0, 5'h00);
        #1 rst = 1'b1;
        cmp_on = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // 1. reset state and idle scan
        @(negedge clk);
        check("t1_rst_en", led_en, 8'hFF);
        check("t1_rst_cx", led_cx, 8'hFF);
        repeat (2) @(negedge clk);
        check("t1_dig0_en", led_en, 8'hFE);
        check("t1_dig0_cx", led_cx, 8'hFF);
        repeat (6) @(negedge clk);
        check("t1_gap_en", led_en, 8'hFF);
        repeat (2) @(negedge clk);
        check("t1_dig1_en", led_en, 8'hFD);
        repeat (54) @(negedge clk);

        // 2. single write, shown on digit 0
        wr(0, 3'd0, 5'h07);
        wait_en(8'hFE, "t2");
        check("t2_cx", led_cx, 8'h1F);

        // 3. contention alternates starting with requester 0
        wr(1, 3'd7, 5'h10);
        @(posedge clk); #1;
        set_req(0, 1'b1, 3'd5, 5'h01);
        set_req(1, 1'b1, 3'd6, 5'h02);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t3_gnt0", {7'b0, wr0.gnt}, {7'b0, (i % 2) == 0});
            check("t3_gnt1", {7'b0, wr1.gnt}, {7'b0, (i % 2) == 1});
            @(posedge clk); #1;
        end
        set_req(0, 1'b0, 3'd0, 5'h00);
        set_req(1, 1'b0, 3'd0, 5'h00);

        // 4. dash, then blank bit overrides value
        wr(0, 3'd3, 5'h0C);
        wait_en(8'hF7, "t4a");
        check("t4_dash", led_cx, 8'hFD);
        wr(1, 3'd3, 5'h15);
        wait_en(8'hF7, "t4b");
        check("t4_blank", led_cx, 8'hFF);

        // 5. write to the lit digit takes effect next frame
        wait_en(8'hFB, "t5a");
        wr(0, 3'd2, 5'h03);
        @(negedge clk);
        check("t5_hold_en", led_en, 8'hFB);
        check("t5_hold_cx", led_cx, 8'hFF);
        wait_en(8'hFB, "t5b");
        check("t5_new_cx", led_cx, 8'h0D);

        // 6. async reset mid-ON with pending req1
        wait_en(8'hFE, "t6a");
        @(posedge clk); #1;
        set_req(1, 1'b1, 3'd4, 5'h05);
        #1 rst = 1'b1;
        #1;
        check("t6_en", led_en, 8'hFF);
        check("t6_cx", led_cx, 8'hFF);
        check("t6_gnt1", {7'b0, wr1.gnt}, 8'h00);
        @(negedge clk);
        set_req(1, 1'b0, 3'd0, 5'h00);
        @(posedge clk); #1 rst = 1'b0;
        wait_en(8'hFE, "t6b");
        check("t6_dig0_cx", led_cx, 8'hFF);
        wait_en(8'hFB, "t6c");
        check("t6_dig2_cx", led_cx, 8'hFF);
        wait_en(8'hDF, "t6d");
        check("t6_dig5_cx", led_cx, 8'hFF);
        repeat (8) @(negedge clk);

        cmp_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
